// File: rtl/tex_scan_loader.sv
// Serial scan frame loader for the texture RAM.
// Frames arrive on phi1/phi2/scan_in. A latch strobe commits a frame as one
// RAM write. All inputs are asynchronous and are synchronized first.
// Write handshake: a write is offered while tex_we is high. tex_addr and
// tex_wdata stay stable while it is offered. The write is accepted on the
// clock edge where tex_we and tex_ready are both high.
module tex_scan_loader #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phi1,
  input  logic              phi2,
  input  logic              scan_in,
  input  logic              latch,
  output logic              tex_we,
  input  logic              tex_ready,
  output logic [ADDR_W-1:0] tex_addr,
  output logic [DATA_W-1:0] tex_wdata,
  output logic              frame_err,
  output logic [ADDR_W:0]   wr_count,
  output logic              load_done
);

  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FW + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FW);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(FW + 1);
  localparam logic [ADDR_W:0] WR_MAX   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {IDLE, PEND} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] phi1_sync, phi2_sync, scan_sync, latch_sync;
  logic phi1_q, phi2_q, latch_q;
  logic phi1_s, phi2_s, scan_s, latch_s;
  logic phi1_rise, phi2_rise, latch_rise;

  logic          master;
  logic [FW-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic          frame_ok;
  logic          load_frame, drop_frame, write_done;

  assign phi1_s  = phi1_sync[SYNC_STAGES-1];
  assign phi2_s  = phi2_sync[SYNC_STAGES-1];
  assign scan_s  = scan_sync[SYNC_STAGES-1];
  assign latch_s = latch_sync[SYNC_STAGES-1];

  assign phi1_rise  = phi1_s & ~phi1_q;
  assign phi2_rise  = phi2_s & ~phi2_q;
  assign latch_rise = latch_s & ~latch_q;

  // The frame is well-formed when exactly FW bits arrived and the start bit is set.
  assign frame_ok  = (bit_cnt == CNT_FULL) && shreg[FW-1];
  assign load_done = wr_count[ADDR_W];

  // Synchronizer chains plus one delayed copy of each strobe for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi1_sync  <= '0;
      phi2_sync  <= '0;
      scan_sync  <= '0;
      latch_sync <= '0;
      phi1_q     <= 1'b0;
      phi2_q     <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      phi1_sync  <= {phi1_sync[SYNC_STAGES-2:0], phi1};
      phi2_sync  <= {phi2_sync[SYNC_STAGES-2:0], phi2};
      scan_sync  <= {scan_sync[SYNC_STAGES-2:0], scan_in};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
      phi1_q     <= phi1_s;
      phi2_q     <= phi2_s;
      latch_q    <= latch_s;
    end
  end

  // Master/slave scan capture. Every latch edge restarts the bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (phi1_rise) master <= scan_s;
      if (phi2_rise) shreg <= {shreg[FW-2:0], master};
      if (latch_rise) begin
        bit_cnt <= '0;
      end else if (phi2_rise && (bit_cnt != CNT_SAT)) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes. A latch edge while a write is pending is an overrun.
  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    drop_frame = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: begin
        if (latch_rise) begin
          if (frame_ok) begin
            load_frame = 1'b1;
            state_nxt  = PEND;
          end else begin
            drop_frame = 1'b1;
          end
        end
      end
      PEND: begin
        if (latch_rise) drop_frame = 1'b1;
        if (tex_we && tex_ready) begin
          write_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered write port, error pulse and saturating write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tex_we    <= 1'b0;
      tex_addr  <= '0;
      tex_wdata <= '0;
      frame_err <= 1'b0;
      wr_count  <= '0;
    end else begin
      frame_err <= drop_frame;
      if (load_frame) begin
        tex_we    <= 1'b1;
        tex_addr  <= shreg[DATA_W +: ADDR_W];
        tex_wdata <= shreg[DATA_W-1:0];
      end else if (write_done) begin
        tex_we <= 1'b0;
        if (wr_count != WR_MAX) wr_count <= wr_count + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_tex_scan_loader.sv
// Bench for tex_scan_loader. The reference model works at the frame level:
// it classifies each committed frame as a write or a drop. It queues the
// expected writes and counts expected drops. A small-address instance
// covers write-counter saturation within a short run.
module tb_tex_scan_loader;

  localparam int A   = 11;
  localparam int D   = 8;
  localparam int FW  = 1 + A + D;
  localparam int SA  = 4;
  localparam int SFW = 1 + SA + D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  logic phi1 = 1'b0, phi2 = 1'b0, scan_in = 1'b0, latch = 1'b0;
  logic tex_ready = 1'b0;
  int   ready_mode = 0;  // 0: low, 1: high, 2: random

  logic         tex_we, frame_err, load_done;
  logic [A-1:0] tex_addr;
  logic [D-1:0] tex_wdata;
  logic [A:0]   wr_count;

  logic          s_we, s_err, s_done;
  logic [SA-1:0] s_addr;
  logic [D-1:0]  s_wdata;
  logic [SA:0]   s_cnt;

  tex_scan_loader dut (
    .clk(clk), .rst(rst_m), .phi1(phi1), .phi2(phi2), .scan_in(scan_in),
    .latch(latch), .tex_we(tex_we), .tex_ready(tex_ready), .tex_addr(tex_addr),
    .tex_wdata(tex_wdata), .frame_err(frame_err), .wr_count(wr_count),
    .load_done(load_done)
  );

  tex_scan_loader #(.ADDR_W(SA), .DATA_W(D), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .rst(rst_s), .phi1(phi1), .phi2(phi2), .scan_in(scan_in),
    .latch(latch), .tex_we(s_we), .tex_ready(tex_ready), .tex_addr(s_addr),
    .tex_wdata(s_wdata), .frame_err(s_err), .wr_count(s_cnt),
    .load_done(s_done)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [A+D-1:0]  exp_q[$];
  logic [SA+D-1:0] sexp_q[$];
  bit pending = 0;
  int model_wr = 0;
  int exp_err = 0;
  int obs_err = 0;
  int err_run = 0;
  int s_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // tex_ready driver, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tex_ready = 1'b0;
      1:       tex_ready = 1'b1;
      default: tex_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Main-instance monitor: write acceptance, hold stability, error pulse width
  logic         prev_we = 1'b0, prev_acc = 1'b0;
  logic [A-1:0] prev_addr = '0;
  logic [D-1:0] prev_data = '0;
  always @(negedge clk) begin
    logic [A+D-1:0] e;
    int n_q;
    if (frame_err) begin
      obs_err++;
      err_run++;
      check("err_width", err_run, 1);
    end else begin
      err_run = 0;
    end
    if (tex_we && prev_we && !prev_acc) begin
      check("hold_addr", 32'(tex_addr), 32'(prev_addr));
      check("hold_data", 32'(tex_wdata), 32'(prev_data));
    end
    if (tex_we && tex_ready) begin
      n_q = exp_q.size();
      check("write_expected", 32'(n_q != 0), 1);
      if (n_q != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(tex_addr), 32'(e[A+D-1:D]));
        check("wr_data", 32'(tex_wdata), 32'(e[D-1:0]));
      end
      pending = 0;
      if (model_wr < (1 << A)) model_wr++;
    end
    prev_we   = tex_we;
    prev_acc  = tex_we && tex_ready;
    prev_addr = tex_addr;
    prev_data = tex_wdata;
  end

  // Small-instance monitor
  always @(negedge clk) begin
    logic [SA+D-1:0] e;
    int n_q;
    if (s_we && tex_ready) begin
      n_q = sexp_q.size();
      check("s_write_expected", 32'(n_q != 0), 1);
      if (n_q != 0) begin
        e = sexp_q.pop_front();
        check("s_wr_addr", 32'(s_addr), 32'(e[SA+D-1:D]));
        check("s_wr_data", 32'(s_wdata), 32'(e[D-1:0]));
      end
      if (s_model < (1 << SA)) s_model++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    scan_in = b;
    cyc(1);
    phi1 = 1'b1;
    cyc(3);
    phi1 = 1'b0;
    phi2 = 1'b1;
    cyc(3);
    phi2 = 1'b0;
    cyc(2);
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    cyc(4);
    latch = 1'b0;
    cyc(4);
  endtask

  // Shift n bits of v into the main instance and commit; the model decides the outcome.
  task automatic main_frame(input logic [31:0] v, input int n);
    send_frame(v, n);
    if (pending) begin
      exp_err++;
    end else if (n == FW && v[FW-1]) begin
      exp_q.push_back(v[A+D-1:0]);
      pending = 1;
    end else begin
      exp_err++;
    end
    latch_pulse();
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400 && (exp_q.size() != 0 || tex_we); k++) cyc(1);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_we_low"}, 32'(tex_we), 0);
    check({tag, "_wr_count"}, 32'(wr_count), model_wr);
    check({tag, "_err_count"}, obs_err, exp_err);
    check({tag, "_load_done"}, 32'(load_done), 32'(model_wr == (1 << A)));
  endtask

  task automatic model_reset();
    exp_q.delete();
    pending = 0;
    model_wr = 0;
  endtask

  function automatic logic [31:0] mk(input logic st, input logic [A-1:0] ad, input logic [D-1:0] da);
    return {12'd0, st, ad, da};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 32'(tex_we), 0);
    check({tag, "_addr"}, 32'(tex_addr), 0);
    check({tag, "_data"}, 32'(tex_wdata), 0);
    check({tag, "_err"}, 32'(frame_err), 0);
    check({tag, "_wr_count"}, 32'(wr_count), 0);
    check({tag, "_load_done"}, 32'(load_done), 0);
  endtask

  // Global time bound
  initial begin
    #3_000_000;
    n_bad++;
    $display("FAIL watchdog: time limit reached before the test sequence ended");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] v;
    logic [A-1:0] ra;
    int n;
    int seen;

    cyc(4);
    check_zero("reset");
    rst_m = 1'b0;
    cyc(3);

    // Basic write
    ready_mode = 1;
    main_frame(mk(1'b1, 11'h2A5, 8'hC3), FW);
    wait_idle("basic");
    check("basic_count_one", 32'(wr_count), 1);

    // Stalled write held for 10 cycles
    ready_mode = 0;
    main_frame(mk(1'b1, 11'h13C, 8'h5A), FW);
    for (int k = 0; k < 10; k++) begin
      check("stall_we", 32'(tex_we), 1);
      cyc(1);
    end
    ready_mode = 1;
    wait_idle("stall");

    // Short frame, start bit 0, then a valid frame
    main_frame(mk(1'b1, 11'h7FF, 8'hFF), FW - 1);
    wait_idle("short");
    main_frame(mk(1'b0, 11'h155, 8'hAA), FW);
    wait_idle("nostart");
    main_frame(mk(1'b1, 11'h0F0, 8'h0F), FW);
    wait_idle("after_bad");

    // Overrun: second frame while first pending
    ready_mode = 0;
    main_frame(mk(1'b1, 11'h321, 8'h11), FW);
    main_frame(mk(1'b1, 11'h456, 8'h22), FW);
    check("overrun_err", obs_err, exp_err);
    ready_mode = 1;
    wait_idle("overrun");

    // Randomized frames: length, start bit, content, ready pattern
    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 4))
        0:       n = FW - 1;
        1:       n = FW + 1;
        default: n = FW;
      endcase
      v = mk(1'($urandom_range(0, 3) != 0), A'($urandom), D'($urandom));
      if (n == FW + 1) v[FW] = 1'($urandom_range(0, 1));
      main_frame(v, n);
      wait_idle("rand");
    end

    // Reset with a partial frame shifted in
    ready_mode = 1;
    send_frame(32'($urandom), 10);
    rst_m = 1'b1;
    #1;
    model_reset();
    check_zero("rst_partial");
    cyc(2);
    rst_m = 1'b0;
    cyc(3);
    main_frame(mk(1'b1, 11'h2A5, 8'h3C), FW);
    wait_idle("post_rst1");

    // Reset while a write is pending
    ready_mode = 0;
    main_frame(mk(1'b1, 11'h600, 8'h77), FW);
    seen = 0;
    for (int k = 0; k < 20 && !tex_we; k++) cyc(1);
    check("pend_before_rst", 32'(tex_we), 1);
    rst_m = 1'b1;
    #1;
    model_reset();
    check_zero("rst_pend");
    cyc(2);
    rst_m = 1'b0;
    ready_mode = 1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (tex_we) seen++;
    end
    check("no_write_after_rst", seen, 0);
    main_frame(mk(1'b1, 11'h001, 8'h99), FW);
    wait_idle("post_rst2");

    // Saturation on the small instance: every address once, then one rewrite
    rst_m = 1'b1;
    rst_s = 1'b1;
    cyc(2);
    rst_s = 1'b0;
    cyc(3);
    for (int a = 0; a <= (1 << SA); a++) begin
      ra = A'(a);
      v = {19'd0, 1'b1, ra[SA-1:0], 8'($urandom)};
      sexp_q.push_back(v[SA+D-1:0]);
      send_frame(v, SFW);
      latch_pulse();
      for (int k = 0; k < 50 && (sexp_q.size() != 0 || s_we); k++) cyc(1);
      check("s_drained", sexp_q.size(), 0);
      check("s_wr_count", 32'(s_cnt), s_model);
      check("s_load_done", 32'(s_done), 32'(s_model == (1 << SA)));
    end
    check("s_err_none", 32'(s_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
